// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the I/D memory arbiter.
package mem_arb_pkg;

    localparam int unsigned WIDTH       = 64;
    localparam int unsigned BLOCKSZ     = 512;
    localparam int unsigned ADDRESSSIZE = 64;

    typedef enum logic {IDLE, WAIT} arb_state_t;

    typedef enum logic {REQ_I, REQ_D} req_id_t;

    typedef struct packed {
        logic [ADDRESSSIZE-1:0] addr;
        logic                   wr_en;
        logic [WIDTH-1:0]       wdata;
    } arb_req_t;

    // With both sides pending, prefer_d decides; otherwise the lone pending side wins.
    function automatic req_id_t pick_winner(input logic pend_i,
                                            input logic pend_d,
                                            input logic prefer_d);
        if (pend_d && (!pend_i || prefer_d))
            return REQ_D;
        return REQ_I;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Cache-side and memory-side signal bundle of the I/D memory arbiter.
interface mem_arb_if #(
    parameter int unsigned WIDTH       = mem_arb_pkg::WIDTH,
    parameter int unsigned BLOCKSZ     = mem_arb_pkg::BLOCKSZ,
    parameter int unsigned ADDRESSSIZE = mem_arb_pkg::ADDRESSSIZE
);

    logic                   i_req;
    logic [ADDRESSSIZE-1:0] i_addr;
    logic                   i_wr_en;
    logic [WIDTH-1:0]       i_wdata;
    logic [BLOCKSZ-1:0]     i_rdata;
    logic                   i_valid;

    logic                   d_req;
    logic [ADDRESSSIZE-1:0] d_addr;
    logic                   d_wr_en;
    logic [WIDTH-1:0]       d_wdata;
    logic [BLOCKSZ-1:0]     d_rdata;
    logic                   d_valid;

    logic                   mem_req;
    logic [ADDRESSSIZE-1:0] mem_address;
    logic                   mem_wr_en;
    logic [WIDTH-1:0]       mem_data_out;
    logic [BLOCKSZ-1:0]     mem_data_in;
    logic                   mem_data_valid;

    // Arbiter side.
    modport slave (
        input  i_req, i_addr, i_wr_en, i_wdata,
        output i_rdata, i_valid,
        input  d_req, d_addr, d_wr_en, d_wdata,
        output d_rdata, d_valid,
        output mem_req, mem_address, mem_wr_en, mem_data_out,
        input  mem_data_in, mem_data_valid
    );

    // Caches and memory side.
    modport master (
        output i_req, i_addr, i_wr_en, i_wdata,
        input  i_rdata, i_valid,
        output d_req, d_addr, d_wr_en, d_wdata,
        input  d_rdata, d_valid,
        input  mem_req, mem_address, mem_wr_en, mem_data_out,
        output mem_data_in, mem_data_valid
    );

endinterface

// File: rtl/mem_arb_req_slot.sv
// One requester's pending flag and captured request fields.
module mem_arb_req_slot
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     req,
    input  arb_req_t req_fields,
    input  logic     done,
    output logic     pend,
    output arb_req_t fields
);

    // A pulse on an already-pending side is dropped, unless that request completes on this same edge.
    logic accept;
    assign accept = req && (!pend || done);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend   <= 1'b0;
            fields <= '0;
        end else if (accept) begin
            pend   <= 1'b1;
            fields <= req_fields;
        end else if (done) begin
            pend   <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between the I and D caches; define MEM_ARB_RR_EN
// for round-robin tie breaking, otherwise D has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    mem_arb_if.slave bus
);

    arb_state_t state, state_next;
    req_id_t    owner, grant_id;
    logic       grant, resp;
    logic       i_done, d_done;
    logic       pend_i, pend_d;
    logic       prefer_d;
    arb_req_t   i_new, d_new;
    arb_req_t   i_fields, d_fields, win;

    assign i_new = '{addr: bus.i_addr, wr_en: bus.i_wr_en, wdata: bus.i_wdata};
    assign d_new = '{addr: bus.d_addr, wr_en: bus.d_wr_en, wdata: bus.d_wdata};

    mem_arb_req_slot u_slot_i (
        .clk        (clk),
        .rst        (rst),
        .req        (bus.i_req),
        .req_fields (i_new),
        .done       (i_done),
        .pend       (pend_i),
        .fields     (i_fields)
    );

    mem_arb_req_slot u_slot_d (
        .clk        (clk),
        .rst        (rst),
        .req        (bus.d_req),
        .req_fields (d_new),
        .done       (d_done),
        .pend       (pend_d),
        .fields     (d_fields)
    );

`ifdef MEM_ARB_RR_EN
    req_id_t last_grant;

    // Only contested grants move the pointer, so an uncontested grant never costs the other side a tie.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= REQ_I;
        else if (grant && pend_i && pend_d)
            last_grant <= grant_id;
    end

    assign prefer_d = (last_grant == REQ_I);
`else
    assign prefer_d = 1'b1;
`endif

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        resp       = 1'b0;
        grant_id   = pick_winner(pend_i, pend_d, prefer_d);
        case (state)
            IDLE: begin
                if (pend_i || pend_d) begin
                    grant      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_data_valid) begin
                    resp       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign i_done = resp && (owner == REQ_I);
    assign d_done = resp && (owner == REQ_D);
    assign win    = (grant_id == REQ_D) ? d_fields : i_fields;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner            <= REQ_I;
            bus.mem_req      <= 1'b0;
            bus.mem_address  <= '0;
            bus.mem_wr_en    <= 1'b0;
            bus.mem_data_out <= '0;
            bus.i_valid      <= 1'b0;
            bus.d_valid      <= 1'b0;
            bus.i_rdata      <= '0;
            bus.d_rdata      <= '0;
        end else begin
            bus.mem_req <= grant;
            bus.i_valid <= i_done;
            bus.d_valid <= d_done;
            if (grant) begin
                owner            <= grant_id;
                bus.mem_address  <= win.addr;
                bus.mem_wr_en    <= win.wr_en;
                bus.mem_data_out <= win.wdata;
            end
            if (i_done)
                bus.i_rdata <= bus.mem_data_in;
            if (d_done)
                bus.d_rdata <= bus.mem_data_in;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a simple latency-configurable memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic [63:0] addr;
        logic        wr;
        logic [63:0] data;
    } mem_exp_t;

    typedef struct {
        logic         rd;
        logic [511:0] data;
    } cpl_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arb_if bus ();

    mem_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_exp_t mem_q[$];
    cpl_exp_t i_q[$];
    cpl_exp_t d_q[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mem_lat  = 1;
    int mreq_cnt = 0;
    int t_mreq   = 0;
    int t_mdv    = 0;
    int t_ival   = 0;
    int t_dval   = 0;

    function automatic logic [511:0] fill_of(input logic [63:0] a);
        return {8{a ^ 64'hA5A5_A5A5_A5A5_A5A5}};
    endfunction

    task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic side_d, input logic [63:0] a, input logic wr,
                            input logic [63:0] wd);
        mem_exp_t m;
        cpl_exp_t c;
        m.addr = a; m.wr = wr; m.data = wd;
        c.rd = !wr; c.data = fill_of(a);
        mem_q.push_back(m);
        if (side_d) d_q.push_back(c);
        else        i_q.push_back(c);
    endtask

    // Called #1 after an edge; the pulse is captured at the next rising edge.
    task automatic pulse(input logic side_d, input logic [63:0] a, input logic wr,
                         input logic [63:0] wd);
        if (side_d) begin
            bus.d_req = 1'b1; bus.d_addr = a; bus.d_wr_en = wr; bus.d_wdata = wd;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = a; bus.i_wr_en = wr; bus.i_wdata = wd;
        end
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while ((mem_q.size() + i_q.size() + d_q.size()) != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_eq({tag, "_drain"}, mem_q.size() + i_q.size() + d_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_mem_req"}, bus.mem_req, 0);
        check_eq({tag, "_mem_address"}, bus.mem_address, 0);
        check_eq({tag, "_mem_wr_en"}, bus.mem_wr_en, 0);
        check_eq({tag, "_mem_data_out"}, bus.mem_data_out, 0);
        check_eq({tag, "_i_valid"}, bus.i_valid, 0);
        check_eq({tag, "_d_valid"}, bus.d_valid, 0);
        check_eq({tag, "_i_rdata"}, bus.i_rdata, 0);
        check_eq({tag, "_d_rdata"}, bus.d_rdata, 0);
    endtask

    // Memory model and output monitor, all sampled on the falling edge.
    initial begin : monitor
        int          resp_wait;
        logic [63:0] resp_addr;
        mem_exp_t    m;
        cpl_exp_t    c;
        resp_wait          = -1;
        resp_addr          = '0;
        bus.mem_data_valid = 1'b0;
        bus.mem_data_in    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.mem_data_valid = 1'b0;
            if (resp_wait == 0) begin
                bus.mem_data_valid = 1'b1;
                bus.mem_data_in    = fill_of(resp_addr);
                t_mdv              = cyc;
                resp_wait          = -1;
            end else if (resp_wait > 0) begin
                resp_wait--;
            end
            if (bus.mem_req) begin
                mreq_cnt++;
                t_mreq = cyc;
                if (mem_q.size() == 0) begin
                    check_eq("mem_req_unexpected", 1, 0);
                end else begin
                    m = mem_q.pop_front();
                    check_eq("mem_address", bus.mem_address, m.addr);
                    check_eq("mem_wr_en", bus.mem_wr_en, m.wr);
                    check_eq("mem_data_out", bus.mem_data_out, m.data);
                end
                resp_wait = mem_lat;
                resp_addr = bus.mem_address;
            end
            if (bus.i_valid) begin
                t_ival = cyc;
                if (i_q.size() == 0) begin
                    check_eq("i_valid_unexpected", 1, 0);
                end else begin
                    c = i_q.pop_front();
                    if (c.rd) check_eq("i_rdata", bus.i_rdata, c.data);
                end
            end
            if (bus.d_valid) begin
                t_dval = cyc;
                if (d_q.size() == 0) begin
                    check_eq("d_valid_unexpected", 1, 0);
                end else begin
                    c = d_q.pop_front();
                    if (c.rd) check_eq("d_rdata", bus.d_rdata, c.data);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   c0;
        int   cnt0;
        logic seen;
        bus.i_req = 1'b0; bus.i_addr = '0; bus.i_wr_en = 1'b0; bus.i_wdata = '0;
        bus.d_req = 1'b0; bus.d_addr = '0; bus.d_wr_en = 1'b0; bus.d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Single D read with minimum memory latency.
        mem_lat = 0;
        push_exp(1'b1, 64'h1040, 1'b0, 64'h0);
        pulse(1'b1, 64'h1040, 1'b0, 64'h0);
        c0 = cyc;
        drain("single", 50);
        check_eq("single_req_latency", t_mreq - c0, 2);
        check_eq("single_valid_latency", t_dval - t_mdv, 1);
        check_eq("single_rdata_hold", bus.d_rdata, fill_of(64'h1040));

        // Simultaneous requests, twice.
        mem_lat = 2;
        push_exp(1'b1, 64'h3000, 1'b0, 64'h0);
        push_exp(1'b0, 64'h2000, 1'b0, 64'h0);
        bus.i_addr = 64'h2000; bus.i_wr_en = 1'b0; bus.i_wdata = '0; bus.i_req = 1'b1;
        pulse(1'b1, 64'h3000, 1'b0, 64'h0);
        drain("tie1", 100);
`ifdef MEM_ARB_RR_EN
        push_exp(1'b0, 64'h2000, 1'b0, 64'h0);
        push_exp(1'b1, 64'h3000, 1'b0, 64'h0);
`else
        push_exp(1'b1, 64'h3000, 1'b0, 64'h0);
        push_exp(1'b0, 64'h2000, 1'b0, 64'h0);
`endif
        bus.i_addr = 64'h2000; bus.i_wr_en = 1'b0; bus.i_wdata = '0; bus.i_req = 1'b1;
        pulse(1'b1, 64'h3000, 1'b0, 64'h0);
        drain("tie2", 100);

        // I-side word write and its ack.
        push_exp(1'b0, 64'h80, 1'b1, 64'hDEAD_BEEF);
        pulse(1'b0, 64'h80, 1'b1, 64'hDEAD_BEEF);
        drain("write", 50);
        check_eq("write_ack_latency", t_ival - t_mdv, 1);

        // D request arriving while an I read waits on memory.
        mem_lat = 4;
        push_exp(1'b0, 64'h9000, 1'b0, 64'h0);
        push_exp(1'b1, 64'hA000, 1'b0, 64'h0);
        pulse(1'b0, 64'h9000, 1'b0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        pulse(1'b1, 64'hA000, 1'b0, 64'h0);
        drain("during_wait", 100);
        check_eq("back_to_back_gap", t_mreq - t_ival, 1);

        // New D request on the very edge its previous request completes.
        mem_lat = 3;
        push_exp(1'b1, 64'hB000, 1'b0, 64'h0);
        push_exp(1'b1, 64'hC000, 1'b0, 64'h0);
        pulse(1'b1, 64'hB000, 1'b0, 64'h0);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk); #1;
            if (bus.mem_data_valid) seen = 1'b1;
        end
        check_eq("same_cycle_seen", seen, 1);
        bus.d_addr = 64'hC000; bus.d_wr_en = 1'b0; bus.d_wdata = '0; bus.d_req = 1'b1;
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        drain("same_cycle", 100);

        // Duplicate pulse on a pending side is dropped.
        cnt0 = mreq_cnt;
        push_exp(1'b1, 64'h4000, 1'b0, 64'h0);
        pulse(1'b1, 64'h4000, 1'b0, 64'h0);
        pulse(1'b1, 64'h5000, 1'b0, 64'h0);
        drain("duplicate", 100);
        repeat (10) @(posedge clk);
        #1;
        check_eq("duplicate_req_count", mreq_cnt - cnt0, 1);
        check_eq("duplicate_rdata", bus.d_rdata, fill_of(64'h4000));

        // Reset during WAIT followed by a stale memory response.
        mem_lat = 6;
        mem_q.push_back('{addr: 64'h6000, wr: 1'b0, data: 64'h0});
        pulse(1'b0, 64'h6000, 1'b0, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("midreset");
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_eq("midreset_mem_q", mem_q.size(), 0);
        check_eq("midreset_i_valid", bus.i_valid, 0);
        push_exp(1'b1, 64'h7000, 1'b0, 64'h0);
        pulse(1'b1, 64'h7000, 1'b0, 64'h0);
        drain("after_reset", 100);
        check_eq("after_reset_rdata", bus.d_rdata, fill_of(64'h7000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
